// File: rtl/fetch_buffer.sv
// Instruction fetch stage: owns the fetch PC, issues one-outstanding word reads and
// queues returned words with their PC for decode. Handles redirect flushes and halt.
module fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     CLK,
  input  logic                     nRST,
  output logic                     imem_ren,
  output logic [31:0]              imem_addr,
  input  logic                     imem_hit,
  input  logic [31:0]              imem_rdata,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  input  logic                     redirect_en,
  input  logic [31:0]              redirect_pc,
  input  logic                     halt,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [1:0]               fsm_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2,
    STOPPED = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [31:0]   req_addr, req_addr_nxt;
  logic          pending, pending_nxt;
  logic          stop_after, stop_after_nxt;

  logic [31:0]   data_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  logic          push, pop, flush;
  logic          handshake, halt_fire;

  // Handshakes: a word moves to decode on a cycle where instr_valid && instr_ready;
  // a memory request completes on a cycle where imem_ren && imem_hit. Neither side
  // may withdraw a raised valid/ren before completion.
  assign handshake   = instr_valid && instr_ready;
  assign halt_fire   = halt && handshake;

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? data_mem[rd_ptr] : 32'h0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr]   : 32'h0;
  assign occupancy   = count;
  assign fsm_state   = state;

  always_comb begin
    state_nxt      = state;
    fetch_pc_nxt   = fetch_pc;
    req_addr_nxt   = req_addr;
    pending_nxt    = pending;
    stop_after_nxt = stop_after;
    push           = 1'b0;
    pop            = 1'b0;
    flush          = 1'b0;
    imem_ren       = 1'b0;
    imem_addr      = pending ? req_addr : fetch_pc;

    case (state)
      IDLE: begin
        state_nxt = FETCH;
      end

      FETCH: begin
        imem_ren = pending || (count < CW'(DEPTH));
        if (halt_fire) begin
          flush = 1'b1;
          if (imem_ren && !imem_hit) begin
            state_nxt      = DISCARD;
            stop_after_nxt = 1'b1;
            pending_nxt    = 1'b1;
            req_addr_nxt   = pending ? req_addr : fetch_pc;
          end else begin
            state_nxt   = STOPPED;
            pending_nxt = 1'b0;
          end
        end else if (redirect_en) begin
          flush        = 1'b1;
          fetch_pc_nxt = {redirect_pc[31:2], 2'b00};
          if (imem_ren && !imem_hit) begin
            state_nxt    = DISCARD;
            pending_nxt  = 1'b1;
            req_addr_nxt = pending ? req_addr : fetch_pc;
          end else begin
            pending_nxt = 1'b0;
          end
        end else begin
          pop = handshake;
          if (imem_ren) begin
            if (imem_hit) begin
              push         = 1'b1;
              fetch_pc_nxt = fetch_pc + 32'd4;
              pending_nxt  = 1'b0;
            end else begin
              pending_nxt  = 1'b1;
              req_addr_nxt = fetch_pc;
            end
          end
        end
      end

      DISCARD: begin
        // The stale request stays on the bus until memory answers; its data is dropped.
        imem_ren = 1'b1;
        if (redirect_en && !stop_after) begin
          fetch_pc_nxt = {redirect_pc[31:2], 2'b00};
        end
        if (imem_hit) begin
          pending_nxt = 1'b0;
          state_nxt   = stop_after ? STOPPED : FETCH;
        end
      end

      STOPPED: begin
        imem_ren = 1'b0;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      req_addr   <= RESET_PC;
      pending    <= 1'b0;
      stop_after <= 1'b0;
    end else begin
      state      <= state_nxt;
      fetch_pc   <= fetch_pc_nxt;
      req_addr   <= req_addr_nxt;
      pending    <= pending_nxt;
      stop_after <= stop_after_nxt;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed scenarios plus randomized traffic, checked every
// cycle against a queue-level model of the fetch stage.
module tb_fetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic        imem_hit = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;
  logic [$clog2(DEPTH):0] occupancy;
  logic [1:0]  fsm_state;

  fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK(CLK), .nRST(nRST),
    .imem_ren(imem_ren), .imem_addr(imem_addr),
    .imem_hit(imem_hit), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .halt(halt), .occupancy(occupancy), .fsm_state(fsm_state)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  assign imem_rdata = imem_hit ? word_at(imem_addr) : 32'hDEAD_BEEF;

  // Reference model: PCs waiting for decode, next PC to fetch, and the one request in flight.
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_out_addr;
  bit          m_out;
  bit          m_started;
  bit          m_dropping;
  bit          m_stop_after;
  bit          m_stopped;

  int checks = 0;
  int errors = 0;

  function automatic bit e_ren();
    if (!m_started || m_stopped) return 1'b0;
    if (m_dropping) return 1'b1;
    return m_out || (exp_q.size() < DEPTH);
  endfunction

  function automatic logic [31:0] e_addr();
    return m_out ? m_out_addr : m_pc;
  endfunction

  task automatic model_init();
    exp_q.delete();
    m_pc = RESET_PC; m_out_addr = RESET_PC; m_out = 0;
    m_started = 0; m_dropping = 0; m_stop_after = 0; m_stopped = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] hp;
    hp = (exp_q.size() > 0) ? exp_q[0] : 32'h0;
    chk({tag, ".ren"},   32'(imem_ren),    32'(e_ren()));
    chk({tag, ".addr"},  imem_addr,        e_addr());
    chk({tag, ".valid"}, 32'(instr_valid), 32'(exp_q.size() > 0));
    chk({tag, ".pc"},    instr_pc,         hp);
    chk({tag, ".instr"}, instr,            (exp_q.size() > 0) ? word_at(hp) : 32'h0);
    chk({tag, ".occ"},   32'(occupancy),   32'(exp_q.size()));
  endtask

  task automatic do_reset(input string tag);
    nRST = 1'b0;
    imem_hit = 0; instr_ready = 0; redirect_en = 0; redirect_pc = 0; halt = 0;
    model_init();
    #3;
    check_outputs(tag);
    chk({tag, ".addr_const"}, imem_addr, RESET_PC);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  // One clock: drive inputs, check pre-edge outputs, advance the model across the edge.
  task automatic cycle(input string tag, input bit hit_req, input bit rdy,
                       input bit redir, input logic [31:0] rpc, input bit hlt);
    bit          er, ev, hit, hs;
    logic [31:0] ea;
    er  = e_ren();
    ea  = e_addr();
    ev  = (exp_q.size() > 0);
    hit = hit_req && er;
    imem_hit = hit; instr_ready = rdy; redirect_en = redir; redirect_pc = rpc; halt = hlt;
    #1;
    check_outputs(tag);
    @(posedge CLK);
    hs = ev && rdy;
    if (!m_started) begin
      m_started = 1;
    end else if (m_stopped) begin
    end else if (m_dropping) begin
      if (redir && !m_stop_after) m_pc = {rpc[31:2], 2'b00};
      if (hit) begin
        m_out = 0; m_dropping = 0;
        if (m_stop_after) m_stopped = 1;
      end
    end else if (hlt && hs) begin
      exp_q.delete();
      if (er && !hit) begin
        m_dropping = 1; m_stop_after = 1; m_out = 1; m_out_addr = ea;
      end else begin
        m_stopped = 1; m_out = 0;
      end
    end else if (redir) begin
      exp_q.delete();
      m_pc = {rpc[31:2], 2'b00};
      if (er && !hit) begin
        m_dropping = 1; m_out = 1; m_out_addr = ea;
      end else begin
        m_out = 0;
      end
    end else begin
      if (hs) void'(exp_q.pop_front());
      if (er) begin
        if (hit) begin
          exp_q.push_back(ea); m_pc = ea + 32'd4; m_out = 0;
        end else begin
          m_out = 1; m_out_addr = ea;
        end
      end
    end
    @(negedge CLK);
  endtask

  initial begin
    model_init();
    do_reset("reset");

    // Streaming: hit and ready every cycle.
    for (int i = 0; i < 8; i++) cycle("stream", 1, 1, 0, 0, 0);

    // Back-pressure until full, single pop, refill.
    for (int i = 0; i < 6; i++) cycle("full", 1, 0, 0, 0, 0);
    chk("full.occ_depth", 32'(occupancy), 32'(DEPTH));
    chk("full.ren_low", 32'(imem_ren), 32'd0);
    cycle("pop1", 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("refill", 1, 0, 0, 0, 0);

    // Redirect with a request outstanding and no hit -> stale data discarded.
    for (int i = 0; i < 5; i++) cycle("drain", 0, 1, 0, 0, 0);
    cycle("rd_out", 0, 1, 0, 0, 0);
    cycle("rd_go", 0, 0, 1, 32'h0000_0103, 0);
    cycle("rd_wait", 0, 0, 0, 0, 0);
    cycle("rd_wait2", 0, 0, 1, 32'h0000_0207, 0);
    cycle("rd_drop", 1, 0, 0, 0, 0);
    chk("rd.new_addr", imem_addr, 32'h0000_0204);
    for (int i = 0; i < 3; i++) cycle("rd_after", 1, 1, 0, 0, 0);

    // Redirect and hit in the same cycle.
    cycle("rdhit", 1, 1, 1, 32'h0000_0300, 0);
    chk("rdhit.addr", imem_addr, 32'h0000_0300);
    chk("rdhit.empty", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 3; i++) cycle("rdhit_after", 1, 0, 0, 0, 0);

    // Halt with entries behind the head and a request outstanding.
    cycle("h_out", 0, 0, 0, 0, 0);
    cycle("h_go", 0, 1, 1, 32'h0000_0400, 1);
    chk("h.valid", 32'(instr_valid), 32'd0);
    cycle("h_wait", 0, 1, 0, 0, 0);
    cycle("h_absorb", 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle("h_stopped", 1, 1, 1, 32'h0000_0500, 0);
    chk("h.ren_off", 32'(imem_ren), 32'd0);

    // PC wrap at the top of the address space, then reset mid-request.
    do_reset("reset2");
    for (int i = 0; i < 6; i++) cycle("wrap_fill", 1, 0, 0, 0, 0);
    cycle("wrap_redir", 1, 0, 1, 32'hFFFF_FFFE, 0);
    cycle("wrap_hit", 1, 0, 0, 0, 0);
    chk("wrap.pc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap.addr", imem_addr, 32'h0000_0000);
    cycle("wrap_out", 0, 0, 0, 0, 0);
    do_reset("reset_mid");

    // Randomized traffic in several reset-separated blocks.
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 150; i++) begin
        cycle("rand",
              ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 9) < 7),
              ($urandom_range(0, 99) < 6),
              $urandom,
              ($urandom_range(0, 99) < 2));
      end
      do_reset("rand_reset");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
